// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU memory bus: widths, R_W encoding,
// responder FSM states and I/O window offsets.
package cpu_bus_pkg;

    localparam int BUS_W = 16;

    localparam logic BUS_WRITE = 1'b1;
    localparam logic BUS_READ  = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } bus_state_e;

    localparam logic [BUS_W-1:0] IO_OUT_OFS = 16'h0000;
    localparam logic [BUS_W-1:0] IO_IN_OFS  = 16'h0001;

endpackage

// File: rtl/bus_word_ram.sv
// Single-port word RAM: synchronous write, combinational read.
module bus_word_ram
    import cpu_bus_pkg::*;
#(
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [BUS_W-1:0]     wdata,
    output logic [BUS_W-1:0]     rdata
);

    logic [BUS_W-1:0] mem_q [2**ADDR_BITS];

    // Write port; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_bus_target.sv
// Memory bus responder: word RAM plus two I/O registers behind a
// programmable wait-state FSM that returns a one-cycle ready strobe.
module mem_bus_target
    import cpu_bus_pkg::*;
#(
    parameter int              ADDR_BITS   = 8,
    parameter int              WAIT_STATES = 2,
    parameter logic [BUS_W-1:0] IO_BASE    = 16'hFF00
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic [BUS_W-1:0] addr_bus,
    input  logic [BUS_W-1:0] data_bus_out,
    input  logic             R_W,
    output logic [BUS_W-1:0] data_bus,
    output logic             ready,
    output logic             err,
    input  logic [BUS_W-1:0] io_in,
    output logic [BUS_W-1:0] io_out
);

    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_ws_check
        $error("mem_bus_target: WAIT_STATES must be in 0..15");
    end

    localparam logic [3:0] WS_CNT = 4'(WAIT_STATES);

    bus_state_e       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [BUS_W-1:0] addr_q, addr_d;
    logic [BUS_W-1:0] wdata_q, wdata_d;
    logic             rw_q, rw_d;
    logic [BUS_W-1:0] rdata_hold_q, rdata_hold_d;
    logic [BUS_W-1:0] io_out_q, io_out_d;

    logic [31:0]      addr_ext;
    logic [BUS_W-1:0] io_ofs;
    logic             io_hit, ram_hit, resp, do_read;
    logic             ram_we;
    logic [BUS_W-1:0] ram_rdata, rd_data;

    bus_word_ram #(.ADDR_BITS(ADDR_BITS)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (addr_q[ADDR_BITS-1:0]),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    // State register and request capture; reset aborts any access in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            rw_q    <= BUS_READ;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rw_q    <= rw_d;
        end
    end

    // Next state: capture in IDLE, count down in WAIT, single RESP cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rw_d    = rw_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    addr_d  = addr_bus;
                    wdata_d = data_bus_out;
                    rw_d    = R_W;
                    cnt_d   = WS_CNT;
                    state_d = (WS_CNT != 4'd0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Address decode and read mux, all from the latched request.
    always_comb begin
        addr_ext = {16'h0000, addr_q};
        io_hit   = (addr_q >= IO_BASE);
        ram_hit  = !io_hit && (addr_ext < (32'd1 << ADDR_BITS));
        io_ofs   = addr_q - IO_BASE;
        rd_data  = '0;
        if (io_hit) begin
            if (io_ofs == IO_OUT_OFS) begin
                rd_data = io_out_q;
            end else if (io_ofs == IO_IN_OFS) begin
                rd_data = io_in;
            end
        end else if (ram_hit) begin
            rd_data = ram_rdata;
        end
    end

    // Outputs and write strobes, active only in the RESP cycle.
    always_comb begin
        resp         = (state_q == ST_RESP);
        do_read      = resp && (rw_q == BUS_READ);
        ready        = resp;
        err          = resp && !io_hit && !ram_hit;
        ram_we       = resp && (rw_q == BUS_WRITE) && ram_hit;
        io_out_d     = io_out_q;
        if (resp && (rw_q == BUS_WRITE) && io_hit && (io_ofs == IO_OUT_OFS)) begin
            io_out_d = wdata_q;
        end
        rdata_hold_d = do_read ? rd_data : rdata_hold_q;
        data_bus     = do_read ? rd_data : rdata_hold_q;
        io_out       = io_out_q;
    end

    // Read-data hold and LED register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_hold_q <= '0;
            io_out_q     <= '0;
        end else begin
            rdata_hold_q <= rdata_hold_d;
            io_out_q     <= io_out_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_target.sv
// Scoreboard bench for mem_bus_target: a WAIT_STATES=2 instance (a) and a
// WAIT_STATES=0 instance (b). Drivers push expected responses; monitors pop
// and compare on every ready strobe, including the cycle it arrives on.
module tb_mem_bus_target;

    typedef struct {
        logic [15:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] io_in = 16'h0000;

    logic        req_a = 1'b0, rw_a = 1'b0;
    logic [15:0] addr_a = 16'h0, wd_a = 16'h0;
    logic [15:0] data_a, io_out_a;
    logic        ready_a, err_a;

    logic        req_b = 1'b0, rw_b = 1'b0;
    logic [15:0] addr_b = 16'h0, wd_b = 16'h0;
    logic [15:0] data_b, io_out_b;
    logic        ready_b, err_b;

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t qa[$];
    exp_t qb[$];
    int   rdy_cyc_a[$];

    mem_bus_target #(.ADDR_BITS(8), .WAIT_STATES(2), .IO_BASE(16'hFF00)) u_dut_a (
        .clk(clk), .reset(reset), .req(req_a), .addr_bus(addr_a),
        .data_bus_out(wd_a), .R_W(rw_a), .data_bus(data_a), .ready(ready_a),
        .err(err_a), .io_in(io_in), .io_out(io_out_a)
    );

    mem_bus_target #(.ADDR_BITS(8), .WAIT_STATES(0), .IO_BASE(16'hFF00)) u_dut_b (
        .clk(clk), .reset(reset), .req(req_b), .addr_bus(addr_b),
        .data_bus_out(wd_b), .R_W(rw_b), .data_bus(data_b), .ready(ready_b),
        .err(err_b), .io_in(io_in), .io_out(io_out_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Monitor for instance a.
    always @(negedge clk) begin
        if (!reset && ready_a) begin
            rdy_cyc_a.push_back(cyc);
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready_a: got ready at cyc %0d expected none", cyc);
            end else begin
                exp_t e;
                e = qa.pop_front();
                $display("txn a cyc=%0d data=%h err=%b (exp data=%h err=%b cyc=%0d)",
                         cyc, data_a, err_a, e.data, e.err, e.cyc);
                chk("data_a", {16'h0, data_a}, {16'h0, e.data});
                chk("err_a", {31'h0, err_a}, {31'h0, e.err});
                chk("ready_cyc_a", cyc, e.cyc);
            end
        end
    end

    // Monitor for instance b.
    always @(negedge clk) begin
        if (!reset && ready_b) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready_b: got ready at cyc %0d expected none", cyc);
            end else begin
                exp_t e;
                e = qb.pop_front();
                $display("txn b cyc=%0d data=%h err=%b (exp data=%h err=%b cyc=%0d)",
                         cyc, data_b, err_b, e.data, e.err, e.cyc);
                chk("data_b", {16'h0, data_b}, {16'h0, e.data});
                chk("err_b", {31'h0, err_b}, {31'h0, e.err});
                chk("ready_cyc_b", cyc, e.cyc);
            end
        end
    end

    // One access on instance a (sel=0) or b (sel=1); exp_d is the data_bus
    // value expected in the ready cycle (held previous read for writes).
    task automatic access(input bit sel, input logic rw, input logic [15:0] a,
                          input logic [15:0] wd, input logic [15:0] exp_d,
                          input logic exp_e);
        exp_t e;
        @(negedge clk);
        e.data = exp_d;
        e.err  = exp_e;
        if (sel) begin
            req_b = 1'b1; rw_b = rw; addr_b = a; wd_b = wd;
            e.cyc = cyc + 1;
            qb.push_back(e);
        end else begin
            req_a = 1'b1; rw_a = rw; addr_a = a; wd_a = wd;
            e.cyc = cyc + 3;
            qa.push_back(e);
        end
        @(posedge clk);
        #1;
        req_a = 1'b0;
        req_b = 1'b0;
        repeat (sel ? 2 : 4) @(posedge clk);
    endtask

    initial begin
        int c;
        int n_win;
        exp_t e;

        repeat (3) @(negedge clk);
        chk("rst_ready_a", {31'h0, ready_a}, 32'h0);
        chk("rst_err_a", {31'h0, err_a}, 32'h0);
        chk("rst_data_a", {16'h0, data_a}, 32'h0);
        chk("rst_io_out_a", {16'h0, io_out_a}, 32'h0);
        chk("rst_ready_b", {31'h0, ready_b}, 32'h0);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        access(0, 1'b1, 16'h0005, 16'h1234, 16'h0000, 1'b0);
        access(0, 1'b0, 16'h0005, 16'h0000, 16'h1234, 1'b0);
        access(0, 1'b1, 16'h0000, 16'h1111, 16'h1234, 1'b0);
        access(0, 1'b1, 16'hFF00, 16'h00A5, 16'h1234, 1'b0);
        chk("io_out_after_write", {16'h0, io_out_a}, 32'h00A5);
        io_in = 16'hBEEF;
        access(0, 1'b0, 16'hFF01, 16'h0000, 16'hBEEF, 1'b0);
        access(0, 1'b1, 16'hFF01, 16'h5555, 16'hBEEF, 1'b0);
        chk("io_out_after_ro_write", {16'h0, io_out_a}, 32'h00A5);
        access(0, 1'b0, 16'hFF00, 16'h0000, 16'h00A5, 1'b0);
        access(0, 1'b0, 16'hFF05, 16'h0000, 16'h0000, 1'b0);
        access(0, 1'b0, 16'h0100, 16'h0000, 16'h0000, 1'b1);
        access(0, 1'b1, 16'h0100, 16'h7777, 16'h0000, 1'b1);
        access(0, 1'b0, 16'h0000, 16'h0000, 16'h1111, 1'b0);

        // req held for 10 cycles: accesses sampled every WAIT_STATES+2 cycles.
        @(negedge clk);
        c = cyc;
        req_a = 1'b1; rw_a = 1'b0; addr_a = 16'h0005;
        for (int k = 0; k < 3; k++) begin
            e.data = 16'h1234;
            e.err  = 1'b0;
            e.cyc  = c + 3 + 4 * k;
            qa.push_back(e);
        end
        rdy_cyc_a.delete();
        repeat (10) @(negedge clk);
        req_a = 1'b0;
        repeat (8) @(posedge clk);
        n_win = 0;
        foreach (rdy_cyc_a[i]) begin
            if (rdy_cyc_a[i] >= c + 1 && rdy_cyc_a[i] <= c + 10) n_win++;
        end
        chk("b2b_pulses_in_window", n_win, 2);
        if (rdy_cyc_a.size() >= 2) begin
            chk("b2b_spacing", rdy_cyc_a[1] - rdy_cyc_a[0], 4);
        end else begin
            chk("b2b_pulse_count", rdy_cyc_a.size(), 2);
        end

        // Reset during WAIT of a write aborts it.
        access(0, 1'b1, 16'h0007, 16'h0707, 16'h1234, 1'b0);
        @(negedge clk);
        req_a = 1'b1; rw_a = 1'b1; addr_a = 16'h0007; wd_a = 16'hDEAD;
        @(posedge clk);
        #1;
        req_a = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_ready", {31'h0, ready_a}, 32'h0);
        chk("abort_io_out", {16'h0, io_out_a}, 32'h0);
        chk("abort_data", {16'h0, data_a}, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        access(0, 1'b0, 16'h0007, 16'h0000, 16'h0707, 1'b0);

        // Zero-wait-state instance.
        access(1, 1'b1, 16'h0005, 16'h5A5A, 16'h0000, 1'b0);
        access(1, 1'b0, 16'h0005, 16'h0000, 16'h5A5A, 1'b0);
        chk("b_io_out", {16'h0, io_out_b}, 32'h0);

        repeat (6) @(posedge clk);
        chk("leftover_a", qa.size(), 0);
        chk("leftover_b", qb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
